// File: rtl/tmds_channel_decoder.sv
// TMDS channel decoder: finds 10-bit symbol alignment in an unaligned
// deserializer stream by hunting for control-token runs, then decodes each
// aligned symbol into pixel data or the C0/C1 control bits with DE.
// Optional build macro TMDS_CHAN_STATS_EN adds the relock_cnt and
// de_run_len link statistics outputs.
module tmds_channel_decoder #(
  parameter int TOKEN_RUN      = 8,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int LOSS_TIMEOUT   = 8192
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic [9:0]  raw_data,
  output logic [7:0]  o_data,
  output logic        o_c0,
  output logic        o_c1,
  output logic        o_de,
  output logic        locked,
  output logic [3:0]  bit_offset
`ifdef TMDS_CHAN_STATS_EN
  ,
  output logic [15:0] relock_cnt,
  output logic [15:0] de_run_len
`endif
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  localparam logic [15:0] RUN_TARGET  = 16'(TOKEN_RUN);
  localparam logic [15:0] TMO_LAST    = 16'(SEARCH_TIMEOUT - 1);
  localparam logic [15:0] LOSS_TARGET = 16'(LOSS_TIMEOUT);

  state_t      state;
  logic [9:0]  raw_prev;
  logic [9:0]  aligned_r;
  logic [9:0]  aligned_next;
  logic [19:0] window;
  logic [15:0] run_cnt;
  logic [15:0] tmo_cnt;
  logic [15:0] gap_cnt;
  logic [15:0] run_inc;
  logic [15:0] gap_inc;
  logic        settle;
  logic        tok_hit;
  logic [1:0]  tok_c;
  logic [7:0]  base;
  logic [7:0]  dec_data;
  logic [3:0]  next_offset;
  logic        lock_now;
  logic        drop_now;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign next_offset = (bit_offset == 4'd9) ? 4'd0 : bit_offset + 4'd1;
  assign run_inc     = sat_inc(run_cnt);
  assign gap_inc     = sat_inc(gap_cnt);
  assign lock_now    = (state == SEARCH) && !settle && tok_hit && (run_inc >= RUN_TARGET);
  assign drop_now    = (state == LOCKED) && !tok_hit && (gap_inc >= LOSS_TARGET);

  // Pick the 10-bit window at the current offset; offsets above 9 never occur
  // so the default slice only exists to keep every window bit referenced.
  always_comb begin
    window = {raw_data, raw_prev};
    case (bit_offset)
      4'd0:    aligned_next = window[9:0];
      4'd1:    aligned_next = window[10:1];
      4'd2:    aligned_next = window[11:2];
      4'd3:    aligned_next = window[12:3];
      4'd4:    aligned_next = window[13:4];
      4'd5:    aligned_next = window[14:5];
      4'd6:    aligned_next = window[15:6];
      4'd7:    aligned_next = window[16:7];
      4'd8:    aligned_next = window[17:8];
      4'd9:    aligned_next = window[18:9];
      default: aligned_next = window[19:10];
    endcase
  end

  // Classify the aligned symbol as one of the four control tokens.
  always_comb begin
    tok_hit = 1'b1;
    tok_c   = 2'b00;
    case (aligned_r)
      10'b1101010100: tok_c = 2'b00;
      10'b0010101011: tok_c = 2'b01;
      10'b0101010100: tok_c = 2'b10;
      10'b1010101011: tok_c = 2'b11;
      default:        tok_hit = 1'b0;
    endcase
  end

  // Undo the TMDS data encoding: optional inversion, then XOR/XNOR chain.
  always_comb begin
    base        = aligned_r[9] ? ~aligned_r[7:0] : aligned_r[7:0];
    dec_data    = 8'h00;
    dec_data[0] = base[0];
    for (int i = 1; i < 8; i++) begin
      dec_data[i] = aligned_r[8] ? (base[i] ^ base[i-1]) : ~(base[i] ^ base[i-1]);
    end
  end

  // Two-stage alignment pipeline: previous word, then the selected window.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      raw_prev  <= 10'd0;
      aligned_r <= 10'd0;
    end else begin
      raw_prev  <= raw_data;
      aligned_r <= aligned_next;
    end
  end

  // Alignment FSM: hunt for a token run at each offset, hold lock until the
  // token gap grows too long. settle masks the one stale symbol after a slip.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state      <= SEARCH;
      locked     <= 1'b0;
      bit_offset <= 4'd0;
      run_cnt    <= 16'd0;
      tmo_cnt    <= 16'd0;
      gap_cnt    <= 16'd0;
      settle     <= 1'b0;
    end else begin
      case (state)
        SEARCH: begin
          if (lock_now) begin
            state   <= LOCKED;
            locked  <= 1'b1;
            run_cnt <= 16'd0;
            tmo_cnt <= 16'd0;
            gap_cnt <= 16'd0;
            settle  <= 1'b0;
          end else if (tmo_cnt >= TMO_LAST) begin
            bit_offset <= next_offset;
            tmo_cnt    <= 16'd0;
            run_cnt    <= 16'd0;
            settle     <= 1'b1;
          end else begin
            tmo_cnt <= sat_inc(tmo_cnt);
            settle  <= 1'b0;
            if (!settle) begin
              run_cnt <= tok_hit ? run_inc : 16'd0;
            end
          end
        end
        LOCKED: begin
          if (drop_now) begin
            state      <= SEARCH;
            locked     <= 1'b0;
            bit_offset <= next_offset;
            gap_cnt    <= 16'd0;
            run_cnt    <= 16'd0;
            tmo_cnt    <= 16'd0;
            settle     <= 1'b1;
          end else if (tok_hit) begin
            gap_cnt <= 16'd0;
          end else begin
            gap_cnt <= gap_inc;
          end
        end
        default: begin
          state  <= SEARCH;
          locked <= 1'b0;
        end
      endcase
    end
  end

  // Output register: blank while unlocked, control bits persist across data.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      o_data <= 8'h00;
      o_c0   <= 1'b0;
      o_c1   <= 1'b0;
      o_de   <= 1'b0;
    end else if (!locked) begin
      o_data <= 8'h00;
      o_c0   <= 1'b0;
      o_c1   <= 1'b0;
      o_de   <= 1'b0;
    end else if (tok_hit) begin
      o_data <= 8'h00;
      o_c0   <= tok_c[0];
      o_c1   <= tok_c[1];
      o_de   <= 1'b0;
    end else begin
      o_data <= dec_data;
      o_de   <= 1'b1;
    end
  end

`ifdef TMDS_CHAN_STATS_EN
  logic        de_next;
  logic [15:0] de_cnt;

  assign de_next = locked && !tok_hit;

  // Count lock losses and capture the length of each finished DE run.
  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      relock_cnt <= 16'd0;
      de_cnt     <= 16'd0;
      de_run_len <= 16'd0;
    end else begin
      if (drop_now) begin
        relock_cnt <= sat_inc(relock_cnt);
      end
      if (de_next) begin
        de_cnt <= o_de ? sat_inc(de_cnt) : 16'd1;
      end else begin
        de_cnt <= 16'd0;
      end
      if (o_de && !de_next) begin
        de_run_len <= de_cnt;
      end
    end
  end
`else
  // Statistics outputs are not built in this configuration.
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: directed alignment scenarios
// plus randomized shifted token/data streams, all compared every cycle
// against a behavioural model built from the symbol rules.
module tb_tmds_channel_decoder;

  localparam int TOKEN_RUN      = 8;
  localparam int SEARCH_TIMEOUT = 64;
  localparam int LOSS_TIMEOUT   = 100;
  localparam logic [9:0] TOKENS [4] = '{10'b1101010100, 10'b0010101011,
                                        10'b0101010100, 10'b1010101011};

  logic       sclk = 1'b0;
  logic       s_rst_n;
  logic [9:0] raw_data;
  logic [7:0] o_data;
  logic       o_c0, o_c1, o_de, locked;
  logic [3:0] bit_offset;
`ifdef TMDS_CHAN_STATS_EN
  logic [15:0] relock_cnt, de_run_len;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  string phase = "reset";

  // behavioural model state
  logic [9:0] m_prev, m_al;
  int m_off, m_run, m_cyc, m_gap, m_relock, m_derun, m_delen;
  bit m_locked, m_de, m_c0, m_c1;
  logic [7:0] m_data;

  int call_idx, lock_call;
  bit locked_seen;
  logic bit_q[$];

  tmds_channel_decoder #(
    .TOKEN_RUN(TOKEN_RUN),
    .SEARCH_TIMEOUT(SEARCH_TIMEOUT),
    .LOSS_TIMEOUT(LOSS_TIMEOUT)
  ) dut (
    .sclk(sclk),
    .s_rst_n(s_rst_n),
    .raw_data(raw_data),
    .o_data(o_data),
    .o_c0(o_c0),
    .o_c1(o_c1),
    .o_de(o_de),
    .locked(locked),
    .bit_offset(bit_offset)
`ifdef TMDS_CHAN_STATS_EN
    ,
    .relock_cnt(relock_cnt),
    .de_run_len(de_run_len)
`endif
  );

  always #5 sclk = ~sclk;

  // One comparison: count it, report a mismatch
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int tokenIndex(input logic [9:0] s);
    for (int c = 0; c < 4; c++) begin
      if (s == TOKENS[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] modelDecode(input logic [9:0] s);
    logic [7:0] x;
    logic [7:0] r;
    x = s[9] ? ~s[7:0] : s[7:0];
    r = x ^ {x[6:0], 1'b0};
    if (!s[8]) r = r ^ 8'hFE;
    return r;
  endfunction

  task automatic modelReset();
    m_prev = '0; m_al = '0; m_off = 0; m_run = 0; m_cyc = 0; m_gap = 0;
    m_relock = 0; m_derun = 0; m_delen = 0;
    m_locked = 0; m_de = 0; m_c0 = 0; m_c1 = 0; m_data = '0;
  endtask

  task automatic modelStep(input logic [9:0] w);
    int tok;
    int old_off;
    bit was_locked;
    bit prev_de;
    bit stale;
    logic [19:0] win;
    tok = tokenIndex(m_al);
    old_off = m_off;
    was_locked = m_locked;
    prev_de = m_de;
    win = {w, m_prev};
    if (!was_locked) begin
      m_de = 0; m_c0 = 0; m_c1 = 0; m_data = '0;
    end else if (tok >= 0) begin
      m_de = 0; m_data = '0; m_c0 = tok[0]; m_c1 = tok[1];
    end else begin
      m_de = 1; m_data = modelDecode(m_al);
    end
    if (m_de) begin
      if (m_delen < 65535) m_delen++;
    end else if (prev_de) begin
      m_derun = m_delen;
      m_delen = 0;
    end
    if (!was_locked) begin
      stale = (m_cyc == 0);
      m_cyc++;
      if (!stale) m_run = (tok >= 0) ? m_run + 1 : 0;
      if (m_run >= TOKEN_RUN) begin
        m_locked = 1; m_gap = 0;
      end else if (m_cyc == SEARCH_TIMEOUT) begin
        m_off = (m_off + 1) % 10; m_cyc = 0; m_run = 0;
      end
    end else if (tok >= 0) begin
      m_gap = 0;
    end else begin
      m_gap++;
      if (m_gap >= LOSS_TIMEOUT) begin
        m_locked = 0; m_off = (m_off + 1) % 10;
        m_cyc = 0; m_run = 0; m_gap = 0;
        if (m_relock < 65535) m_relock++;
      end
    end
    m_al = win[old_off +: 10];
    m_prev = w;
  endtask

  task automatic compareAll(input string tag);
    logic [15:0] obs, exp_v;
    obs   = {locked, bit_offset, o_de, o_c1, o_c0, o_data};
    exp_v = {m_locked, 4'(m_off), m_de, m_c1, m_c0, m_data};
    checkOutput(tag, 32'(obs), 32'(exp_v));
`ifdef TMDS_CHAN_STATS_EN
    checkOutput({tag, "_relock"}, 32'(relock_cnt), 32'(m_relock));
    checkOutput({tag, "_derun"}, 32'(de_run_len), 32'(m_derun));
`endif
  endtask

  // Drive one word, clock it in, advance the model and compare
  task automatic applyStimulus(input logic [9:0] w);
    raw_data = w;
    @(posedge sclk);
    #1;
    modelStep(w);
    call_idx++;
    if (locked) begin
      locked_seen = 1;
      if (lock_call == 0) lock_call = call_idx;
    end
    compareAll(phase);
  endtask

  task automatic pushSym(input logic [9:0] s);
    for (int i = 0; i < 10; i++) bit_q.push_back(s[i]);
  endtask

  task automatic drainBits();
    logic [9:0] w;
    while (bit_q.size() >= 10) begin
      for (int i = 0; i < 10; i++) w[i] = bit_q.pop_front();
      applyStimulus(w);
    end
  endtask

  task automatic doReset();
    s_rst_n = 1'b0;
    raw_data = 10'h3FF;
    #1;
    modelReset();
    compareAll({phase, "_rst"});
    repeat (3) begin
      @(posedge sclk);
      #1;
      compareAll({phase, "_rst_hold"});
    end
    @(negedge sclk);
    s_rst_n = 1'b1;
    call_idx = 0; lock_call = 0; locked_seen = 0;
    bit_q.delete();
  endtask

  task automatic randomBlock(input string name);
    int shift;
    int t;
    phase = name;
    doReset();
    shift = $urandom_range(0, 9);
    for (int i = 0; i < shift; i++) bit_q.push_back(1'($urandom_range(0, 1)));
    for (int n = 0; n < 8; n++) begin
      t = $urandom_range(0, 3);
      repeat (80) pushSym(TOKENS[t]);
      repeat ($urandom_range(1, 30)) pushSym(10'($urandom_range(0, 1023)));
    end
    drainBits();
  endtask

  initial begin
    // reset with all-ones input, outputs must stay zero
    phase = "reset";
    doReset();

    // aligned stream: lock, token decode, first data symbols
    phase = "aligned";
    doReset();
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(TOKENS[0]);
      if (k == 9)  checkOutput("lock_not_yet", 32'(locked), 32'd0);
      if (k == 10) checkOutput("lock_rise", 32'(locked), 32'd1);
      if (k == 11) checkOutput("token_out", 32'({o_de, o_c1, o_c0}), 32'd0);
    end
    applyStimulus(10'h100);
    applyStimulus(10'h2FF);
    applyStimulus(TOKENS[0]);
    checkOutput("data_100", 32'({o_de, o_data}), 32'h100);
    applyStimulus(TOKENS[0]);
    checkOutput("data_2ff", 32'({o_de, o_data}), 32'h1FE);
    checkOutput("aligned_offset", 32'(bit_offset), 32'd0);
    repeat (20) applyStimulus(10'($urandom_range(0, 1023)));

    // boundary at window bit 3, search must step offsets 0..3
    phase = "shift3";
    doReset();
    for (int i = 0; i < 3; i++) bit_q.push_back(1'($urandom_range(0, 1)));
    repeat (260) pushSym(TOKENS[1]);
    drainBits();
    checkOutput("shift3_lock_time", 32'((lock_call > 0) && (lock_call <= 3*64+8+4)), 32'd1);
    checkOutput("shift3_offset", 32'(bit_offset), 32'd3);
    checkOutput("shift3_cbits", 32'({locked, o_c1, o_c0}), 32'b101);

    // broken token runs never lock
    phase = "broken_runs";
    doReset();
    for (int r = 0; r < 38; r++) begin
      repeat (7) applyStimulus(TOKENS[0]);
      applyStimulus(10'h100);
      if (r == 8) begin
        checkOutput("broken_no_lock", 32'(locked_seen), 32'd0);
        checkOutput("broken_offset", 32'(bit_offset), 32'd1);
      end
    end

    // loss of lock after LOSS_TIMEOUT data symbols
    phase = "loss";
    doReset();
    repeat (12) applyStimulus(TOKENS[0]);
    repeat (100) applyStimulus(10'h100);
    checkOutput("loss_still_locked", 32'(locked), 32'd1);
    applyStimulus(TOKENS[0]);
    checkOutput("loss_hold", 32'(locked), 32'd1);
    applyStimulus(TOKENS[0]);
    checkOutput("loss_drop", 32'(locked), 32'd0);
    checkOutput("loss_offset", 32'(bit_offset), 32'd1);
    applyStimulus(TOKENS[0]);
    applyStimulus(TOKENS[0]);
`ifdef TMDS_CHAN_STATS_EN
    checkOutput("loss_relock_cnt", 32'(relock_cnt), 32'd1);
    checkOutput("loss_de_run_len", 32'(de_run_len), 32'd100);
`endif

    // asynchronous reset mid-data, then relock from offset 0
    phase = "async_rst";
    doReset();
    repeat (12) applyStimulus(TOKENS[2]);
    repeat (20) applyStimulus(10'($urandom_range(0, 1023)) | 10'h100);
    #3;
    s_rst_n = 1'b0;
    #1;
    checkOutput("async_outputs", 32'({locked, bit_offset, o_de, o_c1, o_c0, o_data}), 32'd0);
    @(posedge sclk);
    #1;
    modelReset();
    compareAll("async_rst_hold");
    @(negedge sclk);
    s_rst_n = 1'b1;
    call_idx = 0; lock_call = 0;
    repeat (12) applyStimulus(TOKENS[3]);
    repeat (10) applyStimulus(10'($urandom_range(0, 1023)));
    checkOutput("async_relock", 32'({locked, bit_offset}), 32'h10);

    // randomized shifted streams
    randomBlock("random_a");
    randomBlock("random_b");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
